// File: rtl/nat_lookup_arbiter_if.sv
// Handshake bundle between packet-rewrite pipelines, the
// lookup arbiter and the connection-hash engine.
interface nat_lookup_arbiter_if #(
  parameter int NUM_REQ = 2
);
  logic [NUM_REQ*128-1:0] req_tuple_i;
  logic [NUM_REQ-1:0]     req_valid_i;
  logic [NUM_REQ-1:0]     rsp_valid_o;
  logic [15:0]            rsp_data_o;
  logic                   rsp_timeout_o;
  logic [127:0]           tuple_data_o;
  logic                   tuple_valid_o;
  logic [15:0]            conn_data_i;
  logic                   conn_valid_i;

  modport master (
    output req_tuple_i, req_valid_i,
    output conn_data_i, conn_valid_i,
    input  rsp_valid_o, rsp_data_o, rsp_timeout_o,
    input  tuple_data_o, tuple_valid_o
  );

  modport slave (
    input  req_tuple_i, req_valid_i,
    input  conn_data_i, conn_valid_i,
    output rsp_valid_o, rsp_data_o, rsp_timeout_o,
    output tuple_data_o, tuple_valid_o
  );
endinterface

// File: rtl/nat_lookup_arbiter.sv
// Round-robin arbiter sharing one hash lookup engine.
// Optional stats counters: define NAT_ARB_STATS_EN.
module nat_lookup_arbiter #(
  parameter int NUM_REQ        = 2,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                 clk,
  input  logic                 reset,
  nat_lookup_arbiter_if.slave  bus,
  output logic                 busy_o,
  output logic [31:0]          lookup_cnt_o,
  output logic [31:0]          timeout_cnt_o
);

  localparam int GW = $clog2(NUM_REQ);
  localparam int CW = $clog2(TIMEOUT_CYCLES);
  localparam logic [GW-1:0] LAST_REQ = GW'(NUM_REQ - 1);
  localparam logic [CW-1:0] TO_LAST  = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP,
    S_GAP
  } state_t;

  state_t        r_state;
  state_t        w_next;
  logic [GW-1:0] r_last;
  logic [GW-1:0] w_grant;
  logic [GW-1:0] w_cand;
  logic          w_any;
  logic [CW-1:0] r_tcnt;
  logic [127:0]  r_tuple;
  logic [15:0]   r_rsp_data;
  logic          r_rsp_to;
  logic          w_hit;
  logic          w_expire;
  logic          w_take;

  assign w_hit    = (r_state == S_WAIT) && bus.conn_valid_i;
  assign w_expire = (r_state == S_WAIT) && !bus.conn_valid_i
                    && (r_tcnt == TO_LAST);
  assign w_take   = (r_state == S_IDLE) && w_any;

  // Round-robin search starting just after the last grant
  always_comb begin
    w_grant = r_last;
    w_cand  = r_last;
    w_any   = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      w_cand = GW'((int'(r_last) + k) % NUM_REQ);
      if (!w_any && bus.req_valid_i[w_cand]) begin
        w_grant = w_cand;
        w_any   = 1'b1;
      end
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: if (w_any) w_next = S_WAIT;
      S_WAIT: if (w_hit || w_expire) w_next = S_RESP;
      S_RESP: w_next = S_GAP;
      S_GAP:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Grant pointer, latched tuple, timeout counter, response data
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_last     <= LAST_REQ;
      r_tuple    <= '0;
      r_tcnt     <= '0;
      r_rsp_data <= '0;
      r_rsp_to   <= 1'b0;
    end else begin
      if (w_take) begin
        r_last  <= w_grant;
        r_tuple <= bus.req_tuple_i[int'(w_grant)*128 +: 128];
        r_tcnt  <= '0;
      end
      if (r_state == S_WAIT) r_tcnt <= r_tcnt + 1'b1;
      if (w_hit) begin
        r_rsp_data <= bus.conn_data_i;
        r_rsp_to   <= 1'b0;
      end else if (w_expire) begin
        r_rsp_data <= '0;
        r_rsp_to   <= 1'b1;
      end
    end
  end

  // State-decoded outputs
  always_comb begin
    bus.rsp_valid_o   = '0;
    bus.tuple_valid_o = 1'b0;
    busy_o            = (r_state != S_IDLE);
    if (r_state == S_RESP)
      bus.rsp_valid_o = NUM_REQ'(1) << r_last;
    if (r_state == S_WAIT)
      bus.tuple_valid_o = 1'b1;
  end

  assign bus.tuple_data_o  = r_tuple;
  assign bus.rsp_data_o    = r_rsp_data;
  assign bus.rsp_timeout_o = r_rsp_to;

`ifdef NAT_ARB_STATS_EN
  logic [31:0] r_lookup_cnt;
  logic [31:0] r_timeout_cnt;

  // Saturating grant and timeout statistics
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_lookup_cnt  <= '0;
      r_timeout_cnt <= '0;
    end else begin
      if (w_take && (r_lookup_cnt != 32'hFFFF_FFFF))
        r_lookup_cnt <= r_lookup_cnt + 32'd1;
      if ((r_state == S_RESP) && r_rsp_to
          && (r_timeout_cnt != 32'hFFFF_FFFF))
        r_timeout_cnt <= r_timeout_cnt + 32'd1;
    end
  end

  assign lookup_cnt_o  = r_lookup_cnt;
  assign timeout_cnt_o = r_timeout_cnt;
`else
  assign lookup_cnt_o  = '0;
  assign timeout_cnt_o = '0;
`endif

endmodule

// File: tb/tb_nat_lookup_arbiter.sv
// Directed bench for nat_lookup_arbiter.
// NUM_REQ=2, TIMEOUT_CYCLES=8.
module tb_nat_lookup_arbiter;

  localparam logic [127:0] T0 = 128'h11223344_55667788_99AABBCC_DDEEFF00;
  localparam logic [127:0] T1 = 128'hA5A5A5A5_0F0F0F0F_12345678_CAFEBABE;
  localparam logic [127:0] TX = 128'hDEADBEEF_DEADBEEF_DEADBEEF_DEADBEEF;

  logic        clk = 1'b0;
  logic        reset;
  logic        busy_o;
  logic [31:0] lookup_cnt_o;
  logic [31:0] timeout_cnt_o;
  int          n_tests = 0;
  int          n_fail  = 0;

  nat_lookup_arbiter_if #(.NUM_REQ(2)) bus ();

  nat_lookup_arbiter #(
    .NUM_REQ(2),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus),
    .busy_o(busy_o),
    .lookup_cnt_o(lookup_cnt_o),
    .timeout_cnt_o(timeout_cnt_o)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_lookup(input int r, input logic [15:0] d, input bit to);
    bus.req_valid_i = 2'(1 << r);
    cyc();
    if (to) begin
      repeat (8) cyc();
    end else begin
      bus.conn_valid_i = 1'b1;
      bus.conn_data_i  = d;
      cyc();
      bus.conn_valid_i = 1'b0;
    end
    bus.req_valid_i = 2'b00;
    cyc();
    cyc();
  endtask

  task automatic test_reset();
    reset = 1'b0;
    cyc();
    cyc();
    n_tests++;
    if (bus.rsp_valid_o !== 2'b00) begin
      n_fail++;
      $display("FAIL reset_rsp_valid got %b exp 00", bus.rsp_valid_o);
    end
    n_tests++;
    if (bus.tuple_valid_o !== 1'b0 || busy_o !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_tv_busy got %b%b exp 00", bus.tuple_valid_o, busy_o);
    end
    n_tests++;
    if (bus.tuple_data_o !== 128'h0 || bus.rsp_data_o !== 16'h0
        || bus.rsp_timeout_o !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_data got %h %h %b exp 0 0 0",
               bus.tuple_data_o, bus.rsp_data_o, bus.rsp_timeout_o);
    end
    n_tests++;
    if (lookup_cnt_o !== 32'h0 || timeout_cnt_o !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_cnt got %h %h exp 0 0", lookup_cnt_o, timeout_cnt_o);
    end
    reset = 1'b1;
  endtask

  task automatic test_single();
    bus.req_tuple_i = {T1, T0};
    bus.req_valid_i = 2'b01;
    cyc();
    n_tests++;
    if (bus.tuple_valid_o !== 1'b1 || bus.tuple_data_o !== T0) begin
      n_fail++;
      $display("FAIL single_issue got %b %h exp 1 %h",
               bus.tuple_valid_o, bus.tuple_data_o, T0);
    end
    bus.req_tuple_i = {T1, TX};
    cyc();
    cyc();
    n_tests++;
    if (bus.tuple_valid_o !== 1'b1 || bus.tuple_data_o !== T0
        || bus.rsp_valid_o !== 2'b00) begin
      n_fail++;
      $display("FAIL single_hold got %b %h %b exp 1 %h 00",
               bus.tuple_valid_o, bus.tuple_data_o, bus.rsp_valid_o, T0);
    end
    cyc();
    bus.conn_valid_i = 1'b1;
    bus.conn_data_i  = 16'h002A;
    cyc();
    bus.conn_valid_i = 1'b0;
    bus.req_valid_i  = 2'b00;
    n_tests++;
    if (bus.rsp_valid_o !== 2'b01 || bus.rsp_data_o !== 16'h002A
        || bus.rsp_timeout_o !== 1'b0) begin
      n_fail++;
      $display("FAIL single_rsp got %b %h %b exp 01 002a 0",
               bus.rsp_valid_o, bus.rsp_data_o, bus.rsp_timeout_o);
    end
    n_tests++;
    if (bus.tuple_valid_o !== 1'b0) begin
      n_fail++;
      $display("FAIL single_tv_drop got %b exp 0", bus.tuple_valid_o);
    end
    cyc();
    n_tests++;
    if (bus.rsp_valid_o !== 2'b00 || busy_o !== 1'b1
        || bus.rsp_data_o !== 16'h002A) begin
      n_fail++;
      $display("FAIL single_gap got %b %b %h exp 00 1 002a",
               bus.rsp_valid_o, busy_o, bus.rsp_data_o);
    end
    cyc();
    n_tests++;
    if (busy_o !== 1'b0) begin
      n_fail++;
      $display("FAIL single_idle got busy %b exp 0", busy_o);
    end
  endtask

  task automatic test_back_to_back();
    bus.req_tuple_i = {T1, T0};
    bus.req_valid_i = 2'b11;
    reset = 1'b0;
    cyc();
    reset = 1'b1;
    cyc();
    n_tests++;
    if (bus.tuple_data_o !== T0) begin
      n_fail++;
      $display("FAIL rr_grant0 got %h exp %h", bus.tuple_data_o, T0);
    end
    bus.conn_valid_i = 1'b1;
    bus.conn_data_i  = 16'h0005;
    cyc();
    bus.conn_valid_i = 1'b0;
    n_tests++;
    if (bus.rsp_valid_o !== 2'b01 || bus.rsp_data_o !== 16'h0005) begin
      n_fail++;
      $display("FAIL rr_rsp0 got %b %h exp 01 0005",
               bus.rsp_valid_o, bus.rsp_data_o);
    end
    bus.req_valid_i = 2'b10;
    cyc();
    cyc();
    n_tests++;
    if (busy_o !== 1'b0) begin
      n_fail++;
      $display("FAIL rr_gap_nogrant got busy %b exp 0", busy_o);
    end
    cyc();
    n_tests++;
    if (bus.tuple_data_o !== T1 || bus.tuple_valid_o !== 1'b1) begin
      n_fail++;
      $display("FAIL rr_grant1 got %h %b exp %h 1",
               bus.tuple_data_o, bus.tuple_valid_o, T1);
    end
    bus.conn_valid_i = 1'b1;
    bus.conn_data_i  = 16'h0006;
    cyc();
    bus.conn_valid_i = 1'b0;
    n_tests++;
    if (bus.rsp_valid_o !== 2'b10 || bus.rsp_data_o !== 16'h0006) begin
      n_fail++;
      $display("FAIL rr_rsp1 got %b %h exp 10 0006",
               bus.rsp_valid_o, bus.rsp_data_o);
    end
    bus.req_valid_i = 2'b11;
    cyc();
    cyc();
    cyc();
    n_tests++;
    if (bus.tuple_data_o !== T0) begin
      n_fail++;
      $display("FAIL rr_wrap0 got %h exp %h", bus.tuple_data_o, T0);
    end
    bus.conn_valid_i = 1'b1;
    bus.conn_data_i  = 16'h0007;
    cyc();
    bus.conn_valid_i = 1'b0;
    bus.req_valid_i  = 2'b00;
    n_tests++;
    if (bus.rsp_valid_o !== 2'b01) begin
      n_fail++;
      $display("FAIL rr_wrap_rsp got %b exp 01", bus.rsp_valid_o);
    end
    cyc();
    cyc();
  endtask

  task automatic test_timeout();
    bus.req_valid_i = 2'b10;
    cyc();
    repeat (7) cyc();
    n_tests++;
    if (bus.rsp_valid_o !== 2'b00 || bus.tuple_valid_o !== 1'b1) begin
      n_fail++;
      $display("FAIL to_early got %b %b exp 00 1",
               bus.rsp_valid_o, bus.tuple_valid_o);
    end
    cyc();
    bus.req_valid_i = 2'b00;
    n_tests++;
    if (bus.rsp_valid_o !== 2'b10 || bus.rsp_timeout_o !== 1'b1
        || bus.rsp_data_o !== 16'h0) begin
      n_fail++;
      $display("FAIL to_rsp got %b %b %h exp 10 1 0000",
               bus.rsp_valid_o, bus.rsp_timeout_o, bus.rsp_data_o);
    end
    cyc();
    cyc();
    bus.conn_valid_i = 1'b1;
    bus.conn_data_i  = 16'h0077;
    cyc();
    bus.conn_valid_i = 1'b0;
    n_tests++;
    if (bus.rsp_valid_o !== 2'b00 || busy_o !== 1'b0
        || bus.rsp_data_o !== 16'h0 || bus.rsp_timeout_o !== 1'b1) begin
      n_fail++;
      $display("FAIL to_late_ignored got %b %b %h %b exp 00 0 0000 1",
               bus.rsp_valid_o, busy_o, bus.rsp_data_o, bus.rsp_timeout_o);
    end
  endtask

  task automatic test_timeout_race();
    bus.req_valid_i = 2'b01;
    cyc();
    repeat (7) cyc();
    bus.conn_valid_i = 1'b1;
    bus.conn_data_i  = 16'h0BEE;
    cyc();
    bus.conn_valid_i = 1'b0;
    bus.req_valid_i  = 2'b00;
    n_tests++;
    if (bus.rsp_valid_o !== 2'b01 || bus.rsp_timeout_o !== 1'b0
        || bus.rsp_data_o !== 16'h0BEE) begin
      n_fail++;
      $display("FAIL race_rsp got %b %b %h exp 01 0 0bee",
               bus.rsp_valid_o, bus.rsp_timeout_o, bus.rsp_data_o);
    end
    cyc();
    cyc();
  endtask

  task automatic test_reset_mid();
    bus.req_valid_i = 2'b01;
    cyc();
    cyc();
    reset = 1'b0;
    bus.req_valid_i = 2'b00;
    cyc();
    reset = 1'b1;
    n_tests++;
    if (bus.tuple_valid_o !== 1'b0 || busy_o !== 1'b0
        || bus.tuple_data_o !== 128'h0 || bus.rsp_valid_o !== 2'b00) begin
      n_fail++;
      $display("FAIL mid_reset got %b %b %h %b exp 0 0 0 00",
               bus.tuple_valid_o, busy_o, bus.tuple_data_o, bus.rsp_valid_o);
    end
    bus.req_valid_i = 2'b11;
    cyc();
    n_tests++;
    if (bus.tuple_data_o !== T0 || bus.rsp_valid_o !== 2'b00) begin
      n_fail++;
      $display("FAIL mid_prio got %h %b exp %h 00",
               bus.tuple_data_o, bus.rsp_valid_o, T0);
    end
    bus.conn_valid_i = 1'b1;
    bus.conn_data_i  = 16'h0011;
    cyc();
    bus.conn_valid_i = 1'b0;
    bus.req_valid_i  = 2'b10;
    cyc();
    cyc();
    cyc();
    n_tests++;
    if (bus.tuple_data_o !== T1) begin
      n_fail++;
      $display("FAIL mid_req1 got %h exp %h", bus.tuple_data_o, T1);
    end
    bus.conn_valid_i = 1'b1;
    bus.conn_data_i  = 16'h0022;
    cyc();
    bus.conn_valid_i = 1'b0;
    bus.req_valid_i  = 2'b00;
    n_tests++;
    if (bus.rsp_valid_o !== 2'b10 || bus.rsp_data_o !== 16'h0022) begin
      n_fail++;
      $display("FAIL mid_rsp1 got %b %h exp 10 0022",
               bus.rsp_valid_o, bus.rsp_data_o);
    end
    cyc();
    cyc();
  endtask

  task automatic test_stray_conn();
    bus.conn_valid_i = 1'b1;
    bus.conn_data_i  = 16'h0F0F;
    cyc();
    bus.conn_valid_i = 1'b0;
    n_tests++;
    if (bus.rsp_valid_o !== 2'b00 || busy_o !== 1'b0
        || bus.rsp_data_o !== 16'h0022) begin
      n_fail++;
      $display("FAIL stray_idle got %b %b %h exp 00 0 0022",
               bus.rsp_valid_o, busy_o, bus.rsp_data_o);
    end
    bus.req_valid_i = 2'b10;
    cyc();
    bus.conn_valid_i = 1'b1;
    bus.conn_data_i  = 16'h0101;
    cyc();
    bus.conn_valid_i = 1'b0;
    bus.req_valid_i  = 2'b00;
    cyc();
    bus.conn_valid_i = 1'b1;
    bus.conn_data_i  = 16'h0202;
    cyc();
    bus.conn_valid_i = 1'b0;
    n_tests++;
    if (bus.rsp_valid_o !== 2'b00 || busy_o !== 1'b0
        || bus.rsp_data_o !== 16'h0101) begin
      n_fail++;
      $display("FAIL stray_gap got %b %b %h exp 00 0 0101",
               bus.rsp_valid_o, busy_o, bus.rsp_data_o);
    end
    cyc();
    n_tests++;
    if (busy_o !== 1'b0 || bus.rsp_valid_o !== 2'b00) begin
      n_fail++;
      $display("FAIL stray_after got %b %b exp 0 00", busy_o, bus.rsp_valid_o);
    end
  endtask

  task automatic test_stats();
    reset = 1'b0;
    cyc();
    reset = 1'b1;
    do_lookup(0, 16'h0031, 1'b0);
    do_lookup(1, 16'h0000, 1'b1);
    do_lookup(0, 16'h0033, 1'b0);
`ifdef NAT_ARB_STATS_EN
    n_tests++;
    if (lookup_cnt_o !== 32'd3 || timeout_cnt_o !== 32'd1) begin
      n_fail++;
      $display("FAIL stats_on got %0d %0d exp 3 1", lookup_cnt_o, timeout_cnt_o);
    end
`else
    n_tests++;
    if (lookup_cnt_o !== 32'd0 || timeout_cnt_o !== 32'd0) begin
      n_fail++;
      $display("FAIL stats_off got %0d %0d exp 0 0", lookup_cnt_o, timeout_cnt_o);
    end
`endif
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    reset            = 1'b0;
    bus.req_tuple_i  = '0;
    bus.req_valid_i  = '0;
    bus.conn_data_i  = '0;
    bus.conn_valid_i = 1'b0;
    test_reset();
    test_single();
    test_back_to_back();
    test_timeout();
    test_timeout_race();
    test_reset_mid();
    test_stray_conn();
    test_stats();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
